// File: rtl/input_stream_node_2d.sv
// rtl/input_stream_node_2d.sv - 2D strided OBI word fetcher feeding a credit-limited output FIFO
module input_stream_node_2d #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 execute_i,
  input  logic                 clear_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] inner_count_i,
  input  logic [15:0]          inner_stride_i,
  input  logic [CNT_WIDTH-1:0] outer_count_i,
  input  logic [31:0]          outer_stride_i,
  output struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  }                            masters_req_o,
  input  struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  }                            masters_resp_i,
  output logic [31:0]          dout_o,
  output logic                 dout_v_o,
  input  logic                 dout_r_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;

  state_t               r_state, w_next_state;
  logic [31:0]          r_addr, r_row_addr;
  logic [CNT_WIDTH-1:0] r_inner_idx, r_outer_idx;
  logic [AW:0]          r_outstanding, r_usage;
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [31:0]          r_mem [FIFO_DEPTH];

  logic                 w_req, w_gnt, w_push, w_pop, w_start;
  logic                 w_last_in_row, w_last, w_credit_ok;
  logic [AW+1:0]        w_in_use;
  logic [31:0]          w_next_row;

  assign w_start       = (r_state == S_IDLE) && execute_i;
  assign w_gnt         = w_req && masters_resp_i.gnt;
  // Late responses after a reset are not ours to buffer
  assign w_push        = masters_resp_i.rvalid && ((r_state == S_REQ) || (r_state == S_DRAIN));
  assign w_pop         = dout_v_o && dout_r_i;
  assign w_last_in_row = (r_inner_idx == inner_count_i - CNT_WIDTH'(1));
  assign w_last        = w_last_in_row && (r_outer_idx == outer_count_i - CNT_WIDTH'(1));
  assign w_in_use      = {1'b0, r_outstanding} + {1'b0, r_usage};
  assign w_credit_ok   = (w_in_use < DEPTH_L);
  assign w_next_row    = r_row_addr + outer_stride_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (execute_i)
                 w_next_state = ((inner_count_i != '0) && (outer_count_i != '0)) ? S_REQ : S_DONE;
      S_REQ:   if (w_gnt && w_last) w_next_state = S_DRAIN;
      S_DRAIN: if ((r_outstanding == '0) && (r_usage == '0)) w_next_state = S_DONE;
      S_DONE:  if (clear_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_req  = (r_state == S_REQ) && w_credit_ok;
    busy_o = (r_state == S_REQ) || (r_state == S_DRAIN);
    done_o = (r_state == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_row_addr  <= '0;
      r_inner_idx <= '0;
      r_outer_idx <= '0;
    end else if (w_start) begin
      r_addr      <= base_addr_i;
      r_row_addr  <= base_addr_i;
      r_inner_idx <= '0;
      r_outer_idx <= '0;
    end else if (w_gnt) begin
      if (w_last_in_row) begin
        r_inner_idx <= '0;
        r_outer_idx <= r_outer_idx + CNT_WIDTH'(1);
        r_row_addr  <= w_next_row;
        r_addr      <= w_next_row;
      end else begin
        r_inner_idx <= r_inner_idx + CNT_WIDTH'(1);
        r_addr      <= r_addr + {16'b0, inner_stride_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_usage       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      case ({w_gnt, w_push})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + 1'b1;
        2'b01:   r_usage <= r_usage - 1'b1;
        default: r_usage <= r_usage;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= masters_resp_i.rdata;
  end

  assign dout_o   = r_mem[r_rd_ptr];
  assign dout_v_o = (r_usage != '0);

  assign masters_req_o.req   = w_req;
  assign masters_req_o.we    = 1'b0;
  assign masters_req_o.be    = 4'b1111;
  assign masters_req_o.addr  = r_addr;
  assign masters_req_o.wdata = 32'h0;

endmodule

// File: tb/tb_input_stream_node_2d.sv
// tb/tb_input_stream_node_2d.sv - directed bench with an in-order OBI memory model
module tb_input_stream_node_2d;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  logic        clk = 0, rst_n = 0, execute = 0, clear = 0, dout_r = 0;
  logic [31:0] base = 0, ostride = 0;
  logic [15:0] inner = 0, outer = 0, istride = 0;
  obi_req_t    mreq;
  obi_resp_t   mresp = '0;
  logic [31:0] dout;
  logic        dout_v, busy, done;

  int checks = 0, failures = 0;
  int cyc = 0, inflight = 0, lat_max = 0;
  bit gnt_rand = 0, prev_req = 0, prev_gnt = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] got_addr[$], got_data[$], exp_addr[$], pend_d[$];
  int          pend_t[$];

  input_stream_node_2d #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .execute_i(execute), .clear_i(clear),
    .base_addr_i(base), .inner_count_i(inner), .inner_stride_i(istride),
    .outer_count_i(outer), .outer_stride_i(ostride),
    .masters_req_o(mreq), .masters_resp_i(mresp),
    .dout_o(dout), .dout_v_o(dout_v), .dout_r_i(dout_r),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: drives gnt/rvalid on the falling edge, returns data in grant order
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_d.delete(); pend_t.delete();
      inflight = 0; prev_req = 0; prev_gnt = 0;
      mresp = '0;
    end else begin
      if (prev_req && !prev_gnt) begin
        chk("req_held", {31'b0, mreq.req}, 32'd1);
        chk("addr_held", mreq.addr, prev_addr);
      end
      mresp.rvalid = 1'b0;
      if (pend_d.size() > 0 && pend_t[0] <= cyc) begin
        mresp.rvalid = 1'b1;
        mresp.rdata  = pend_d.pop_front();
        void'(pend_t.pop_front());
      end
      mresp.gnt = mreq.req && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (mresp.gnt) begin
        got_addr.push_back(mreq.addr);
        pend_d.push_back(mreq.addr ^ KEY);
        pend_t.push_back(cyc + 1 + int'($urandom_range(0, lat_max)));
        inflight++;
      end
      if (dout_v && dout_r) begin
        got_data.push_back(dout);
        inflight--;
      end
      chk("no_overflow", {31'b0, inflight <= DEPTH}, 32'd1);
      prev_req = mreq.req; prev_gnt = mresp.gnt; prev_addr = mreq.addr;
    end
  end

  task automatic build_exp();
    exp_addr.delete();
    for (int o = 0; o < int'(outer); o++)
      for (int i = 0; i < int'(inner); i++)
        exp_addr.push_back(base + 32'(o) * ostride + 32'(i) * {16'b0, istride});
  endtask

  task automatic start(input logic [31:0] b, input logic [15:0] ic, input logic [15:0] is,
                       input logic [15:0] oc, input logic [31:0] os);
    got_addr.delete(); got_data.delete();
    base = b; inner = ic; istride = is; outer = oc; ostride = os;
    build_exp();
    @(posedge clk); #1 execute = 1;
    @(posedge clk); #1 execute = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic check_lists(input string tag);
    chk({tag, "_ngrant"}, got_addr.size(), exp_addr.size());
    chk({tag, "_nword"}, got_data.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k < got_addr.size()) chk($sformatf("%s_addr%0d", tag, k), got_addr[k], exp_addr[k]);
      if (k < got_data.size()) chk($sformatf("%s_data%0d", tag, k), got_data[k], exp_addr[k] ^ KEY);
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, mreq.req}, 32'd0);
    chk("rst_dout_v", {31'b0, dout_v}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1 rst_n = 1;

    // 1D contiguous
    dout_r = 1;
    start(32'h1000, 16'd8, 16'd4, 16'd1, 32'd0);
    @(negedge clk);
    chk("1d_first_req", {31'b0, mreq.req}, 32'd1);
    chk("1d_we_be_wdata", {mreq.we, mreq.be, mreq.wdata[26:0]}, {1'b0, 4'hF, 27'd0});
    wait_done("1d", 200);
    check_lists("1d");
    chk("1d_a0", got_addr.size() > 0 ? got_addr[0] : 32'hX, 32'h1000);
    chk("1d_a7", got_addr.size() > 7 ? got_addr[7] : 32'hX, 32'h101C);
    chk("1d_busy_at_done", {31'b0, busy}, 32'd0);
    do_clear();
    @(negedge clk);
    chk("1d_cleared", {31'b0, done}, 32'd0);

    // 2D
    start(32'h2000, 16'd3, 16'd8, 16'd2, 32'h100);
    wait_done("2d", 200);
    check_lists("2d");
    chk("2d_a3", got_addr.size() > 3 ? got_addr[3] : 32'hX, 32'h2100);
    chk("2d_a5", got_addr.size() > 5 ? got_addr[5] : 32'hX, 32'h2110);
    do_clear();

    // Backpressure: consumer stalled, credits cap grants at FIFO_DEPTH
    dout_r = 0;
    start(32'h3000, 16'd16, 16'd4, 16'd1, 32'd0);
    repeat (30) @(negedge clk);
    chk("bp_grants", got_addr.size(), DEPTH);
    chk("bp_req_low", {31'b0, mreq.req}, 32'd0);
    chk("bp_dout_v", {31'b0, dout_v}, 32'd1);
    chk("bp_dout_head", dout, 32'h3000 ^ KEY);
    @(posedge clk); #1 dout_r = 1;
    wait_done("bp", 300);
    check_lists("bp");
    do_clear();

    // Random grant and response latencies
    gnt_rand = 1; lat_max = 3;
    start(32'h4000, 16'd5, 16'h10, 16'd3, 32'h200);
    wait_done("stall", 2000);
    check_lists("stall");
    do_clear();
    gnt_rand = 0; lat_max = 0;

    // Zero count
    start(32'h7000, 16'd0, 16'd4, 16'd5, 32'h100);
    @(negedge clk);
    chk("zc_done", {31'b0, done}, 32'd1);
    chk("zc_req", {31'b0, mreq.req}, 32'd0);
    chk("zc_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("zc_no_grant", got_addr.size(), 32'd0);
    do_clear();
    @(negedge clk);
    chk("zc_cleared", {31'b0, done}, 32'd0);
    start(32'h6000, 16'd2, 16'd4, 16'd2, 32'h40);
    wait_done("zc2", 200);
    check_lists("zc2");
    do_clear();

    // Reset mid-run
    start(32'h8000, 16'd10, 16'd4, 16'd1, 32'd0);
    begin
      int n = 0;
      while (got_addr.size() < 5 && n < 100) begin @(negedge clk); n++; end
      chk("mr_five_grants", {31'b0, got_addr.size() >= 5}, 32'd1);
    end
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("mr_req", {31'b0, mreq.req}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_done", {31'b0, done}, 32'd0);
    chk("mr_dout_v", {31'b0, dout_v}, 32'd0);
    chk("mr_addr", mreq.addr, 32'd0);
    @(posedge clk); #1 rst_n = 1;
    start(32'h5000, 16'd4, 16'd4, 16'd1, 32'd0);
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    @(negedge clk);
    chk("mr_clear_ignored", {31'b0, busy}, 32'd1);
    wait_done("mr", 200);
    check_lists("mr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
